// File: rtl/gtp_init_seq_if.sv
// Control/status bundle between system logic, the GTP quads and the GTP init sequencer.
// Latency: none, wires only.
// Backpressure: none; start is a one-cycle request and every other signal is a level.
// Optional GTP_INIT_SEQ_DEBUG_EN adds dbg_state and relock_cnt.
interface gtp_init_seq_if #(
    parameter int NUM_CH = 2
);
    logic              start;
    logic [NUM_CH-1:0] ch_pll_sel;
    logic              pll0_lock;
    logic              pll1_lock;
    logic [NUM_CH-1:0] tx_resetdone;
    logic [NUM_CH-1:0] rx_resetdone;
    logic              pll0_reset;
    logic              pll1_reset;
    logic [NUM_CH-1:0] gttxreset;
    logic [NUM_CH-1:0] gtrxreset;
    logic              ready;
    logic              error;
    logic [1:0]        retry_cnt;
`ifdef GTP_INIT_SEQ_DEBUG_EN
    logic [2:0]        dbg_state;
    logic [7:0]        relock_cnt;
`endif

    // System and transceiver side: requests init, reports lock and resetdone.
    modport master (
        output start, ch_pll_sel, pll0_lock, pll1_lock, tx_resetdone, rx_resetdone,
        input  pll0_reset, pll1_reset, gttxreset, gtrxreset, ready, error, retry_cnt
`ifdef GTP_INIT_SEQ_DEBUG_EN
        , input dbg_state, relock_cnt
`endif
    );

    // Sequencer side.
    modport slave (
        input  start, ch_pll_sel, pll0_lock, pll1_lock, tx_resetdone, rx_resetdone,
        output pll0_reset, pll1_reset, gttxreset, gtrxreset, ready, error, retry_cnt
`ifdef GTP_INIT_SEQ_DEBUG_EN
        , output dbg_state, relock_cnt
`endif
    );
endinterface

// File: rtl/gtp_init_seq.sv
// GTP reset/init sequencer: pulses the PLL resets, waits for lock, pulses the channel resets, waits for resetdone, and retries on timeout.
// Latency: lock/resetdone inputs see 2 synchroniser cycles, and outputs follow the state register, so a state's outputs appear the cycle after entry.
// Backpressure: none; start always restarts the sequence. Optional GTP_INIT_SEQ_DEBUG_EN adds dbg_state and relock_cnt.
module gtp_init_seq #(
    parameter int NUM_CH         = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int CH_RST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int DONE_TIMEOUT   = 4096,
    parameter int MAX_RETRY      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    gtp_init_seq_if.slave bus
);
    localparam int TMO_MAX = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
    localparam int CNT_W   = $clog2(TMO_MAX) + 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CH_RST_LAST  = CNT_W'(CH_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DONE_LAST    = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLL_RST  = 3'd1,
        S_PLL_WAIT = 3'd2,
        S_CH_RST   = 3'd3,
        S_CH_WAIT  = 3'd4,
        S_READY    = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        retry_cnt;
    logic              retry_inc;
    logic [NUM_CH-1:0] sel_q;

    logic [1:0]        pll0_sync;
    logic [1:0]        pll1_sync;
    logic [NUM_CH-1:0] tx_sync0, tx_sync1;
    logic [NUM_CH-1:0] rx_sync0, rx_sync1;

    // A PLL is needed only if at least one channel was latched onto it.
    logic need_pll0, need_pll1, locks_ok, done_ok, can_retry, cnt_run;
    assign need_pll0 = ~&sel_q;
    assign need_pll1 = |sel_q;
    assign locks_ok  = (!need_pll0 || pll0_sync[1]) && (!need_pll1 || pll1_sync[1]);
    assign done_ok   = (&tx_sync1) && (&rx_sync1);
    assign can_retry = (retry_cnt < RETRY_MAX);
    assign cnt_run   = (state == S_PLL_RST) || (state == S_PLL_WAIT) ||
                       (state == S_CH_RST)  || (state == S_CH_WAIT);

    // Two-flop synchronisers for the asynchronous lock and resetdone levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pll0_sync <= '0;
            pll1_sync <= '0;
            tx_sync0  <= '0;
            tx_sync1  <= '0;
            rx_sync0  <= '0;
            rx_sync1  <= '0;
        end else begin
            pll0_sync <= {pll0_sync[0], bus.pll0_lock};
            pll1_sync <= {pll1_sync[0], bus.pll1_lock};
            tx_sync0  <= bus.tx_resetdone;
            tx_sync1  <= tx_sync0;
            rx_sync0  <= bus.rx_resetdone;
            rx_sync1  <= rx_sync0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state: start wins over everything; a timeout either retries or gives up.
    always_comb begin
        state_nxt = state;
        retry_inc = 1'b0;
        if (bus.start) begin
            state_nxt = S_PLL_RST;
        end else begin
            case (state)
                S_IDLE:     state_nxt = S_IDLE;
                S_PLL_RST:  if (cnt == PLL_RST_LAST) state_nxt = S_PLL_WAIT;
                S_PLL_WAIT: begin
                    if (locks_ok) begin
                        state_nxt = S_CH_RST;
                    end else if (cnt == LOCK_LAST) begin
                        state_nxt = can_retry ? S_PLL_RST : S_FAIL;
                        retry_inc = can_retry;
                    end
                end
                S_CH_RST:   if (cnt == CH_RST_LAST) state_nxt = S_CH_WAIT;
                S_CH_WAIT: begin
                    if (done_ok) begin
                        state_nxt = S_READY;
                    end else if (cnt == DONE_LAST) begin
                        state_nxt = can_retry ? S_PLL_RST : S_FAIL;
                        retry_inc = can_retry;
                    end
                end
                S_READY: begin
                    if (!locks_ok)     state_nxt = S_PLL_RST;
                    else if (!done_ok) state_nxt = S_CH_RST;
                end
                S_FAIL:     state_nxt = S_FAIL;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    // Phase counter restarts on every state entry (start counts as re-entry); retry and channel map are owned by start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            retry_cnt <= '0;
            sel_q     <= '0;
        end else begin
            if (bus.start) sel_q <= bus.ch_pll_sel;
            if (bus.start)      retry_cnt <= '0;
            else if (retry_inc) retry_cnt <= retry_cnt + 2'd1;
            if (bus.start || (state_nxt != state)) cnt <= '0;
            else if (cnt_run)                     cnt <= cnt + CNT_W'(1);
        end
    end

    // Outputs decoded from state; an unneeded PLL is held in reset throughout.
    always_comb begin
        bus.pll0_reset = 1'b1;
        bus.pll1_reset = 1'b1;
        bus.gttxreset  = '1;
        bus.gtrxreset  = '1;
        bus.ready      = 1'b0;
        bus.error      = 1'b0;
        case (state)
            S_PLL_WAIT, S_CH_RST: begin
                bus.pll0_reset = !need_pll0;
                bus.pll1_reset = !need_pll1;
            end
            S_CH_WAIT: begin
                bus.pll0_reset = !need_pll0;
                bus.pll1_reset = !need_pll1;
                bus.gttxreset  = '0;
                bus.gtrxreset  = '0;
            end
            S_READY: begin
                bus.pll0_reset = !need_pll0;
                bus.pll1_reset = !need_pll1;
                bus.gttxreset  = '0;
                bus.gtrxreset  = '0;
                bus.ready      = 1'b1;
            end
            S_FAIL:  bus.error = 1'b1;
            default: bus.error = 1'b0;
        endcase
    end

    assign bus.retry_cnt = retry_cnt;

`ifdef GTP_INIT_SEQ_DEBUG_EN
    logic [7:0] relock_cnt;

    // Saturating count of READY->PLL_RST transitions, only cleared by rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n)
            relock_cnt <= '0;
        else if ((state == S_READY) && (state_nxt == S_PLL_RST) && (relock_cnt != 8'hFF))
            relock_cnt <= relock_cnt + 8'd1;
    end

    assign bus.dbg_state  = state;
    assign bus.relock_cnt = relock_cnt;
`endif
endmodule

// File: tb/tb_gtp_init_seq.sv
// Self-checking bench for gtp_init_seq: table vectors, hand-written corner sequences and randomized runs.
// Reactive transceiver model raises lock/resetdone a set delay after the resets fall.
// Expected outcomes come from an attempt-count model of the retry rules.
module tb_gtp_init_seq;
    localparam int NCH = 2;
    localparam int PRC = 4;
    localparam int CRC = 4;
    localparam int TMO = 64;
    localparam int MR  = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    gtp_init_seq_if #(.NUM_CH(NCH)) bus ();

    gtp_init_seq #(
        .NUM_CH(NCH), .PLL_RST_CYCLES(PRC), .CH_RST_CYCLES(CRC),
        .LOCK_TIMEOUT(TMO), .DONE_TIMEOUT(TMO), .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        int         n_fail;
        int         lock_dly;
        int         done_dly;
        logic       exp_ready;
        logic       exp_error;
        logic [1:0] exp_retry;
        int         exp_falls;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // The sequencer gets MAX_RETRY+1 lock attempts; each one the PLL ignores burns a full timeout.
    function automatic void model(input int n_fail, output logic r, output logic e,
                                  output logic [1:0] rc, output int falls, output int last_low);
        if (n_fail <= MR) begin
            r = 1'b1; e = 1'b0; rc = 2'(n_fail); falls = n_fail + 1;
        end else begin
            r = 1'b0; e = 1'b1; rc = 2'(MR); falls = MR + 1;
        end
        last_low = (n_fail > 0) ? TMO : 0;
    endfunction

    // One start-to-outcome run; PLL locks only once n_fail reset pulses have gone unanswered.
    task automatic check_run(input string tag, input logic [1:0] sel, input int n_fail,
                             input int lock_dly, input int done_dly);
        logic ready_o, error_o, ur_low, req, prev_req, prev_gtx, req_end;
        logic [1:0] retry_o, gtx_end, e_retry;
        logic e_ready, e_error;
        int falls, first_w, last_low, run_lo, lock_at, done_at, e_falls, e_low;
        model(n_fail, e_ready, e_error, e_retry, e_falls, e_low);
        bus.ch_pll_sel   = sel;
        bus.pll0_lock    = 1'b0;
        bus.pll1_lock    = 1'b0;
        bus.tx_resetdone = '0;
        bus.rx_resetdone = '0;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        falls = 0; first_w = 0; last_low = 0; run_lo = 0; lock_at = -1; done_at = -1;
        ur_low = 1'b0; prev_req = 1'b1; prev_gtx = 1'b1; req = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            req = (sel != 2'b11) ? bus.pll0_reset : bus.pll1_reset;
            if (sel == 2'b00 && bus.pll1_reset !== 1'b1) ur_low = 1'b1;
            if (sel == 2'b11 && bus.pll0_reset !== 1'b1) ur_low = 1'b1;
            if (falls == 0 && req) first_w++;
            if (prev_req && !req) begin
                falls++;
                if (falls > n_fail) lock_at = cyc + lock_dly;
            end
            if (!req) run_lo++;
            else if (!prev_req) begin
                last_low = run_lo;
                run_lo   = 0;
            end
            if (prev_gtx && !bus.gttxreset[0]) done_at = cyc + done_dly;
            if (cyc == lock_at) begin
                if (sel != 2'b11) bus.pll0_lock = 1'b1;
                if (sel != 2'b00) bus.pll1_lock = 1'b1;
            end
            if (cyc == done_at) begin
                bus.tx_resetdone = '1;
                bus.rx_resetdone = '1;
            end
            prev_req = req;
            prev_gtx = bus.gttxreset[0];
            if (bus.ready === 1'b1 || bus.error === 1'b1) break;
            step();
        end
        ready_o = bus.ready; error_o = bus.error; retry_o = bus.retry_cnt;
        req_end = req; gtx_end = bus.gttxreset;
        chk({tag, "_ready"},      ready_o,  e_ready);
        chk({tag, "_error"},      error_o,  e_error);
        chk({tag, "_retry"},      retry_o,  e_retry);
        chk({tag, "_attempts"},   falls,    e_falls);
        chk({tag, "_pll_pulse"},  first_w,  PRC);
        chk({tag, "_wait_len"},   last_low, e_low);
        chk({tag, "_unreq_low"},  ur_low,   1'b0);
        chk({tag, "_pll_rst_end"}, req_end, e_error);
        chk({tag, "_gttx_end"},   gtx_end,  e_error ? 2'b11 : 2'b00);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll0_rst"}, bus.pll0_reset, 1'b1);
        chk({tag, "_pll1_rst"}, bus.pll1_reset, 1'b1);
        chk({tag, "_gttx"},     bus.gttxreset,  2'b11);
        chk({tag, "_gtrx"},     bus.gtrxreset,  2'b11);
        chk({tag, "_ready"},    bus.ready,      1'b0);
        chk({tag, "_error"},    bus.error,      1'b0);
        chk({tag, "_retry"},    bus.retry_cnt,  2'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, wtx, wrx;
        logic pll_hi, restored;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.ch_pll_sel = '0;
        bus.pll0_lock = 1'b0; bus.pll1_lock = 1'b0;
        bus.tx_resetdone = '0; bus.rx_resetdone = '0;
        repeat (3) step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (4) step();
        chk("idle_hold_pll0", bus.pll0_reset, 1'b1);
        chk("idle_hold_gttx", bus.gttxreset, 2'b11);

        vecs[0] = '{2'b00, 0, 10, 10, 1'b1, 1'b0, 2'd0, 1};
        vecs[1] = '{2'b11, 1,  5,  3, 1'b1, 1'b0, 2'd1, 2};
        vecs[2] = '{2'b01, 2, 20, 30, 1'b1, 1'b0, 2'd2, 3};
        vecs[3] = '{2'b10, 0,  1,  1, 1'b1, 1'b0, 2'd0, 1};
        vecs[4] = '{2'b00, 3,  5,  5, 1'b0, 1'b1, 2'd2, 3};
        for (int i = 0; i < 5; i++) begin
            logic r, e; logic [1:0] rc; int f, l;
            model(vecs[i].n_fail, r, e, rc, f, l);
            chk($sformatf("vec%0d_model_ready", i), r,  vecs[i].exp_ready);
            chk($sformatf("vec%0d_model_falls", i), f,  vecs[i].exp_falls);
            check_run($sformatf("vec%0d", i), vecs[i].sel, vecs[i].n_fail,
                      vecs[i].lock_dly, vecs[i].done_dly);
        end

        // Start out of FAIL clears the error at once.
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("fail_start_error", bus.error, 1'b0);
        chk("fail_start_retry", bus.retry_cnt, 2'd0);
        chk("fail_start_pll0",  bus.pll0_reset, 1'b1);

        // Lock loss in READY goes back through the PLL reset and recovers.
        check_run("relock_setup", 2'b10, 0, 5, 5);
        bus.pll1_lock = 1'b0;
        n = 0;
        while (bus.ready !== 1'b0 && n < 10) begin step(); n++; end
        chk("relock_ready_drop_cycles", (n <= 3), 1'b1);
        chk("relock_pll1_rst", bus.pll1_reset, 1'b1);
        chk("relock_retry",    bus.retry_cnt, 2'd0);
        n = 0;
        while (bus.pll1_reset !== 1'b0 && n < 20) begin step(); n++; end
        bus.pll1_lock = 1'b1;
        n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin step(); n++; end
        chk("relock_ready_back", bus.ready, 1'b1);
        chk("relock_retry_kept", bus.retry_cnt, 2'd0);

        // Resetdone loss alone only re-pulses the channel resets.
        bus.rx_resetdone[1] = 1'b0;
        pll_hi = 1'b0; restored = 1'b0; wtx = 0; wrx = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (bus.pll0_reset || bus.pll1_reset) pll_hi = 1'b1;
            if (bus.gttxreset[0]) wtx++;
            if (bus.gtrxreset[1]) wrx++;
            if (wtx > 0 && !bus.gttxreset[0] && !restored) begin
                bus.rx_resetdone[1] = 1'b1;
                restored = 1'b1;
            end
            if (restored && bus.ready) break;
        end
        chk("chrst_pll_stay_low", pll_hi, 1'b0);
        chk("chrst_gttx_width", wtx, CRC);
        chk("chrst_gtrx_width", wrx, CRC);
        chk("chrst_ready_back", bus.ready, 1'b1);

        // Start landing on the exact timeout edge wins over the retry.
        bus.ch_pll_sel = 2'b00; bus.pll0_lock = 1'b0; bus.pll1_lock = 1'b0;
        bus.tx_resetdone = '0; bus.rx_resetdone = '0;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        n = 0;
        while (bus.pll0_reset !== 1'b0 && n < 20) begin step(); n++; end
        chk("race_in_wait", bus.pll0_reset, 1'b0);
        repeat (TMO - 1) step();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("race_pll_rst", bus.pll0_reset, 1'b1);
        chk("race_retry",   bus.retry_cnt, 2'd0);
        n = 0;
        while (bus.pll0_reset !== 1'b0 && n < 20) begin step(); n++; end
        n = 0;
        while (bus.pll0_reset !== 1'b1 && n < 100) begin step(); n++; end
        chk("race_then_timeout_retry", bus.retry_cnt, 2'd1);
        n = 0;
        while (bus.pll0_reset !== 1'b0 && n < 20) begin step(); n++; end
        bus.pll0_lock = 1'b1;
        n = 0;
        while (bus.gttxreset !== 2'b00 && n < 100) begin step(); n++; end
        chk("chwait_reached", bus.gttxreset, 2'b00);
        repeat (3) step();
        rst_n = 1'b0; step(); 
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        repeat (5) step();
        chk("midrst_stays_idle_pll0", bus.pll0_reset, 1'b1);
        chk("midrst_stays_idle_gttx", bus.gttxreset, 2'b11);

        // Randomized runs against the attempt-count model.
        for (int it = 0; it < 8; it++) begin
            check_run($sformatf("rnd%0d", it), 2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(1, 40)),
                      int'($urandom_range(1, 40)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
